// File: rtl/cgra0_pe_in_reader.sv
// Input-side FIFO reader for a 7-thread round-robin PE. It pops words for live threads,
// delivers each word one cycle after its pop, and tracks 64-bit per-thread quantities.
module cgra0_pe_in_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 7,
  parameter int unsigned QTD_WIDTH   = 64,
  parameter int unsigned TID_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [TID_W-1:0]       thread_idx,
  input  logic                   fifo_re_req,
  input  logic [TID_W-1:0]       thread_id,
  input  logic [QTD_WIDTH/2-1:0] qtd_low,
  input  logic                   qtd_we_low,
  input  logic [QTD_WIDTH/2-1:0] qtd_high,
  input  logic                   qtd_we_high,
  input  logic                   fifo_empty,
  output logic                   fifo_re,
  input  logic [DATA_WIDTH-1:0]  fifo_data_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic                   stall,
  output logic [NUM_THREADS-1:0] thread_done,
  output logic                   done_all
);

  localparam int unsigned HALF_W = QTD_WIDTH / 2;

  logic [QTD_WIDTH-1:0]   limit_q [NUM_THREADS];
  logic [QTD_WIDTH-1:0]   limit_d [NUM_THREADS];
  logic [QTD_WIDTH-1:0]   count_q [NUM_THREADS];
  logic [QTD_WIDTH-1:0]   count_d [NUM_THREADS];
  logic                   pop_q;
  logic                   pop_d;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  data_d;
  logic                   valid_q;
  logic                   valid_d;

  logic [NUM_THREADS-1:0] done_c;
  logic                   idx_ok_c;
  logic                   idx_done_c;
  logic                   live_c;
  logic                   fifo_re_c;
  logic                   stall_c;

  // Completion flags straight from the registered limit/count pairs.
  always_comb begin
    done_c = '0;
    for (int t = 0; t < int'(NUM_THREADS); t++) begin
      done_c[t] = (count_q[t] == limit_q[t]);
    end
  end

  // Slots beyond the last thread behave as permanently done.
  always_comb begin
    idx_ok_c   = (thread_idx < TID_W'(NUM_THREADS));
    idx_done_c = 1'b1;
    if (idx_ok_c) begin
      idx_done_c = done_c[thread_idx];
    end
    live_c    = fifo_re_req & ~idx_done_c;
    fifo_re_c = live_c & ~fifo_empty & en;
    stall_c   = live_c & fifo_empty;
  end

  // Configuration writes ignore en; a low-half write also re-arms the counter and beats a pop.
  always_comb begin
    for (int t = 0; t < int'(NUM_THREADS); t++) begin
      limit_d[t] = limit_q[t];
      count_d[t] = count_q[t];
      if (qtd_we_high && (thread_id == TID_W'(t))) begin
        limit_d[t][QTD_WIDTH-1:HALF_W] = qtd_high;
      end
      if (qtd_we_low && (thread_id == TID_W'(t))) begin
        limit_d[t][HALF_W-1:0] = qtd_low;
        count_d[t]             = '0;
      end else if (fifo_re_c && (thread_idx == TID_W'(t))) begin
        count_d[t] = count_q[t] + QTD_WIDTH'(1);
      end
    end
  end

  // Delivery stage: the popped word arrives one cycle later; a held pop survives en low.
  always_comb begin
    pop_d   = pop_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      pop_d   = fifo_re_c;
      valid_d = pop_q;
      data_d  = pop_q ? fifo_data_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
        limit_q[t] <= '0;
        count_q[t] <= '0;
      end
      pop_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
        limit_q[t] <= limit_d[t];
        count_q[t] <= count_d[t];
      end
      pop_q   <= pop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign fifo_re     = fifo_re_c;
  assign stall       = stall_c;
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign thread_done = done_c;
  assign done_all    = &done_c;

endmodule

// File: tb/tb_cgra0_pe_in_reader.sv
// Scoreboard bench for cgra0_pe_in_reader: a quantity/queue reference model predicts pops,
// stalls and completion; a monitor matches delivered words against the expected queue.
module tb_cgra0_pe_in_reader;

  localparam int NT = 7;

  logic        clk = 1'b0;
  logic        rst, en, fifo_re_req, qtd_we_low, qtd_we_high, fifo_empty;
  logic [2:0]  thread_idx, thread_id;
  logic [31:0] qtd_low, qtd_high, fifo_data_in, data_out;
  logic        fifo_re, data_valid, stall, done_all;
  logic [6:0]  thread_done;

  int checks = 0;
  int errors = 0;

  logic [63:0] lim [NT];
  logic [63:0] cnt [NT];
  logic [31:0] tbfifo [$];
  logic [31:0] exp_q [$];
  logic        force_empty;
  logic        popped;
  logic [31:0] popw;

  always #5 clk = ~clk;

  cgra0_pe_in_reader dut (
    .clk(clk), .rst(rst), .en(en), .thread_idx(thread_idx), .fifo_re_req(fifo_re_req),
    .thread_id(thread_id), .qtd_low(qtd_low), .qtd_we_low(qtd_we_low), .qtd_high(qtd_high),
    .qtd_we_high(qtd_we_high), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_data_in(fifo_data_in), .data_out(data_out), .data_valid(data_valid), .stall(stall),
    .thread_done(thread_done), .done_all(done_all)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: predict from the model, compare, then advance the model past the edge.
  task automatic tick();
    logic [6:0] dvec;
    logic       live, epop, estall;
    int         ti;
    fifo_empty = force_empty || (tbfifo.size() == 0);
    @(negedge clk);
    for (int t = 0; t < NT; t++) dvec[t] = (cnt[t] == lim[t]);
    ti   = int'(thread_idx);
    live = 1'b0;
    if (fifo_re_req && ti < NT) begin
      if (!dvec[ti]) live = 1'b1;
    end
    epop   = live && !fifo_empty && en;
    estall = live && fifo_empty;
    chk("thread_done", 64'(thread_done), 64'(dvec));
    chk("done_all", 64'(done_all), 64'(&dvec));
    chk("fifo_re", 64'(fifo_re), 64'(epop));
    chk("stall", 64'(stall), 64'(estall));
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        lim[t] = '0;
        cnt[t] = '0;
      end
      exp_q.delete();
    end else begin
      if (epop) exp_q.push_back(tbfifo[0]);
      for (int t = 0; t < NT; t++) begin
        if (qtd_we_high && int'(thread_id) == t) lim[t][63:32] = qtd_high;
        if (qtd_we_low && int'(thread_id) == t) begin
          lim[t][31:0] = qtd_low;
          cnt[t] = '0;
        end else if (epop && ti == t) begin
          cnt[t] = cnt[t] + 64'd1;
        end
      end
    end
    popped = 1'b0;
    if (fifo_re === 1'b1 && tbfifo.size() > 0) begin
      popw   = tbfifo.pop_front();
      popped = 1'b1;
    end
    @(posedge clk);
    #2;
    if (popped) fifo_data_in = popw;
    qtd_we_low  = 1'b0;
    qtd_we_high = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_re_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int t, input logic [31:0] hi, input logic [31:0] lo);
    thread_id = 3'(t); qtd_high = hi; qtd_we_high = 1'b1;
    tick();
    thread_id = 3'(t); qtd_low = lo; qtd_we_low = 1'b1;
    tick();
  endtask

  task automatic req(input int t);
    fifo_re_req = 1'b1; thread_idx = 3'(t);
    tick();
    fifo_re_req = 1'b0;
  endtask

  // Monitor: whenever the delivery registers advance, match them against the scoreboard.
  initial begin
    logic en_s, rst_s;
    forever begin
      @(negedge clk);
      en_s  = en;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (rst_s) begin
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
      end else if (en_s) begin
        if (data_valid === 1'b1) begin
          if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
          else chk("data_out", 64'(data_out), 64'(exp_q.pop_front()));
        end else begin
          chk("data_valid", 64'(data_valid), 64'd0);
          chk("idle_data_out", 64'(data_out), 64'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; fifo_re_req = 1'b0; thread_idx = '0; thread_id = '0;
    qtd_low = '0; qtd_high = '0; qtd_we_low = 1'b0; qtd_we_high = 1'b0;
    fifo_empty = 1'b1; fifo_data_in = '0; force_empty = 1'b0; popped = 1'b0; popw = '0;
    for (int t = 0; t < NT; t++) begin
      lim[t] = '0;
      cnt[t] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    do_reset();
    en = 1'b1;

    // Thread 2 limited to three words out of four offered
    cfg(2, 32'd0, 32'd3);
    tbfifo = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) req(2);
    repeat (2) tick();
    tbfifo.delete();

    // Thread 0 stalls on an empty FIFO while en is dropped, then pops when data shows up
    cfg(0, 32'd0, 32'd2);
    force_empty = 1'b1;
    fifo_re_req = 1'b1; thread_idx = 3'd0;
    tick();
    en = 1'b0;
    repeat (3) tick();
    tbfifo.push_back(32'h5A5A_0001);
    force_empty = 1'b0; en = 1'b1;
    tick();
    fifo_re_req = 1'b0;
    repeat (2) tick();

    // All seven threads interleaved, one word each
    do_reset();
    for (int t = 0; t < NT; t++) cfg(t, 32'd0, 32'd1);
    for (int t = 0; t < NT; t++) tbfifo.push_back(32'hC0DE_0000 + 32'(t));
    for (int t = 0; t < NT; t++) req(t);
    repeat (2) tick();

    // Upper limit half must take part in the compare; a high rewrite alone does not clear count
    cfg(4, 32'd1, 32'd2);
    tbfifo = '{32'h44, 32'h45, 32'h46};
    for (int i = 0; i < 3; i++) req(4);
    thread_id = 3'd4; qtd_high = 32'd0; qtd_we_high = 1'b1;
    tick();
    req(4);
    tbfifo.delete();

    // Low write coinciding with a pop on the same thread restarts the count
    cfg(1, 32'd0, 32'd3);
    for (int i = 0; i < 8; i++) tbfifo.push_back(32'h1000 + 32'(i));
    req(1);
    thread_id = 3'd1; qtd_low = 32'd5; qtd_we_low = 1'b1;
    req(1);
    for (int i = 0; i < 6; i++) req(1);
    repeat (2) tick();
    tbfifo.delete();

    // Reset lands while a popped word is in flight
    cfg(3, 32'd0, 32'd4);
    tbfifo.push_back(32'hDEAD_BEEF);
    req(3);
    do_reset();
    tbfifo.delete();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0 && tbfifo.size() < 8) tbfifo.push_back($urandom);
      en          = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 9) == 0);
      fifo_re_req = ($urandom_range(0, 3) != 0);
      thread_idx  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) begin
        thread_id = 3'($urandom_range(0, 7)); qtd_low = 32'($urandom_range(0, 4)); qtd_we_low = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        if (!qtd_we_low) thread_id = 3'($urandom_range(0, 7));
        qtd_high = 32'($urandom_range(0, 3) == 0); qtd_we_high = 1'b1;
      end
      tick();
    end

    fifo_re_req = 1'b0; en = 1'b1; force_empty = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
